// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one column driven low at a time, rows debounced,
// each accepted press presented as a 4-bit code under a valid/ack handshake.
module keypad_scanner #(
  parameter int unsigned SCAN_CYCLES     = 6000,
  parameter int unsigned DEBOUNCE_CYCLES = 60000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       overrun
);

  localparam int unsigned MAX_CYCLES = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES
                                                                       : DEBOUNCE_CYCLES;
  localparam int unsigned CNT_W = $clog2(MAX_CYCLES);

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  // Row synchronizer; only rows_s_q is visible to the FSM.
  logic [3:0]       sync1_q;
  logic [3:0]       rows_s_q;

  logic [1:0]       state_q,     state_d;
  logic [1:0]       col_idx_q,   col_idx_d;
  logic [1:0]       row_idx_q,   row_idx_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [3:0]       cols_q,      cols_d;
  logic [3:0]       key_q,       key_d;
  logic             key_valid_q, key_valid_d;
  logic             overrun_q,   overrun_d;

  logic             accept;
  logic             row_low;

  // Lowest-index low row wins when several keys in one column are down.
  function automatic logic [1:0] first_low(input logic [3:0] r);
    logic [1:0] idx;
    casez (r)
      4'b???0: idx = 2'd0;
      4'b??01: idx = 2'd1;
      4'b?011: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  assign row_low = ~rows_s_q[row_idx_q];

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    row_idx_d = row_idx_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;

    case (state_q)
      ST_SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (rows_s_q != 4'b1111) begin
            row_idx_d = first_low(rows_s_q);
            state_d   = ST_DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DEBOUNCE: begin
        if (!row_low) begin
          state_d   = ST_SCAN;
          col_idx_d = col_idx_q + 2'd1;
          cnt_d     = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_HELD;
          cnt_d   = '0;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_HELD: begin
        cnt_d = '0;
        if (!row_low) begin
          state_d = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        // A low row here is bounce or a re-press of the same key: no new code.
        if (row_low) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d   = ST_SCAN;
          col_idx_d = col_idx_q + 2'd1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_SCAN;
        cnt_d   = '0;
      end
    endcase
  end

  assign cols_d = ~(4'b0001 << col_idx_d);

  // Handshake: an acceptance always wins over a same-cycle ack; overrun is
  // only flagged when an unacknowledged code is overwritten.
  always_comb begin
    key_d       = key_q;
    key_valid_d = key_valid_q;
    overrun_d   = overrun_q;
    if (accept) begin
      key_d       = {row_idx_q, col_idx_q};
      key_valid_d = 1'b1;
      if (key_valid_q && !key_ack) begin
        overrun_d = 1'b1;
      end
    end else if (key_ack) begin
      key_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q     <= 4'b1111;
      rows_s_q    <= 4'b1111;
      state_q     <= ST_SCAN;
      col_idx_q   <= 2'd0;
      row_idx_q   <= 2'd0;
      cnt_q       <= '0;
      cols_q      <= 4'b1110;
      key_q       <= 4'h0;
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= rows;
      rows_s_q    <= sync1_q;
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      cnt_q       <= cnt_d;
      cols_q      <= cols_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign cols      = cols_q;
  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign overrun   = overrun_q;

endmodule
